// File: rtl/multiplier_reg_pkg.sv
// Shared constants and vector types for the registered multiplier.
// Holds the default operand width plus operand/product typedefs at that width.
package multiplier_reg_pkg;

    // Default operand width; the product is twice this wide.
    localparam int BITWIDTH_DEFAULT = 32;

    typedef logic [BITWIDTH_DEFAULT-1:0]   operand_t;
    typedef logic [2*BITWIDTH_DEFAULT-1:0] product_t;

endpackage

// File: rtl/multiplier_reg_core.sv
// Combinational shift-add array multiplier, full 2*BITWIDTH product, no state.
// Ports: iData0/iData1 operands (BITWIDTH), oProduct product (2*BITWIDTH).
// MULTIPLIER_REG_SIGNED_EN selects two's-complement (Baugh-Wooley) operands.
module multiplier_reg_core
    import multiplier_reg_pkg::*;
#(
    parameter int BITWIDTH = BITWIDTH_DEFAULT
) (
    input  logic [BITWIDTH-1:0]   iData0,
    input  logic [BITWIDTH-1:0]   iData1,
    output logic [2*BITWIDTH-1:0] oProduct
);

    logic [2*BITWIDTH-1:0] acc;
    logic [BITWIDTH-1:0]   row;
    logic [2*BITWIDTH-1:0] one;

    always_comb begin
        acc = '0;
        row = '0;
        one = {{(2*BITWIDTH-1){1'b0}}, 1'b1};
        for (int i = 0; i < BITWIDTH; i++) begin
            for (int j = 0; j < BITWIDTH; j++) begin
                row[j] = iData0[j] & iData1[i];
`ifdef MULTIPLIER_REG_SIGNED_EN
                // Baugh-Wooley: invert terms pairing exactly one sign bit.
                if ((i == BITWIDTH-1) != (j == BITWIDTH-1))
                    row[j] = ~row[j];
`endif
            end
            acc = acc + ({{BITWIDTH{1'b0}}, row} << i);
        end
`ifdef MULTIPLIER_REG_SIGNED_EN
        // Correction constant 2^W + 2^(2W-1), taken mod 2^(2W).
        acc = acc + (one << BITWIDTH) + (one << (2*BITWIDTH-1));
`endif
        oProduct = acc;
    end

endmodule

// File: rtl/multiplier_reg.sv
// Registered multiplier: one-cycle latency product with clear and enable.
// Ports: iClk, iRstN (async low), iEn, iClr (sync, beats iEn), iData0, iData1, oData.
// MULTIPLIER_REG_SIGNED_EN selects signed operands/product (default unsigned).
module multiplier_reg
    import multiplier_reg_pkg::*;
#(
    parameter int BITWIDTH = BITWIDTH_DEFAULT
) (
    input  logic                  iClk,
    input  logic                  iRstN,
    input  logic                  iEn,
    input  logic                  iClr,
    input  logic [BITWIDTH-1:0]   iData0,
    input  logic [BITWIDTH-1:0]   iData1,
    output logic [2*BITWIDTH-1:0] oData
);

    logic [2*BITWIDTH-1:0] product;

    multiplier_reg_core #(
        .BITWIDTH (BITWIDTH)
    ) uCore (
        .iData0   (iData0),
        .iData1   (iData1),
        .oProduct (product)
    );

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            oData <= '0;
        end else if (iClr) begin
            oData <= '0;
        end else if (iEn) begin
            oData <= product;
        end
    end

endmodule

// File: tb/tb_multiplier_reg.sv
// Self-checking bench for multiplier_reg at BITWIDTH=32.
// Expected products are queued when driven and popped one edge later.
module tb_multiplier_reg;

    logic        iClk = 1'b0;
    logic        iRstN;
    logic        iEn;
    logic        iClr;
    logic [31:0] iData0;
    logic [31:0] iData1;
    logic [63:0] oData;

    logic [63:0] model;
    logic [63:0] expQ[$];
    int          nCmp = 0;
    int          nBad = 0;

    multiplier_reg #(
        .BITWIDTH (32)
    ) dut (
        .iClk   (iClk),
        .iRstN  (iRstN),
        .iEn    (iEn),
        .iClr   (iClr),
        .iData0 (iData0),
        .iData1 (iData1),
        .oData  (oData)
    );

    always #5 iClk = ~iClk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        nCmp++;
        if (got !== exp) begin
            nBad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mul(input logic [31:0] a,
                                        input logic [31:0] b);
`ifdef MULTIPLIER_REG_SIGNED_EN
        return {{32{a[31]}}, a} * {{32{b[31]}}, b};
`else
        return {32'd0, a} * {32'd0, b};
`endif
    endfunction

    // Drive one cycle, push the expectation, check it after the edge.
    task automatic step(input string tag, input logic en, input logic clr,
                        input logic [31:0] a, input logic [31:0] b);
        iEn    = en;
        iClr   = clr;
        iData0 = a;
        iData1 = b;
        if (clr)
            model = '0;
        else if (en)
            model = mul(a, b);
        expQ.push_back(model);
        @(posedge iClk);
        #1;
        if (expQ.size() == 0)
            chk({tag, "_empty"}, oData, 64'hx);
        else
            chk(tag, oData, expQ.pop_front());
    endtask

    initial begin
        iRstN  = 1'b0;
        iEn    = 1'b1;
        iClr   = 1'b0;
        iData0 = 32'd10;
        iData1 = 32'd20;
        model  = '0;

        #2;
        chk("rst_async", oData, 64'd0);
        repeat (3) begin
            @(posedge iClk);
            #1;
            chk("rst_hold", oData, 64'd0);
        end

        iRstN = 1'b1;
        step("first", 1'b1, 1'b0, 32'd10, 32'd20);
        chk("first_c8", oData, 64'hC8);

        step("clr", 1'b1, 1'b1, 32'd10, 32'd20);
        repeat (40)
            step("clr_hold", 1'b1, 1'b1, 32'd10, 32'd20);

        step("load63", 1'b1, 1'b0, 32'd7, 32'd9);
        repeat (3)
            step("hold63", 1'b0, 1'b0, 32'd3, 32'd3);
        chk("hold63_lit", oData, 64'd63);

        step("holdx", 1'b0, 1'b0, 32'hx, 32'hx);

        step("max", 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
`ifdef MULTIPLIER_REG_SIGNED_EN
        chk("max_lit", oData, 64'd1);
        step("neg2", 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0002);
        chk("neg2_lit", oData, 64'hFFFF_FFFF_FFFF_FFFE);
        step("minmin", 1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000);
        chk("minmin_lit", oData, 64'h4000_0000_0000_0000);
`else
        chk("max_lit", oData, 64'hFFFF_FFFE_0000_0001);
`endif

        step("zero", 1'b1, 1'b0, 32'd0, 32'hDEAD_BEEF);
        step("one", 1'b1, 1'b0, 32'd1, 32'hDEAD_BEEF);

        for (int k = 0; k < 40; k++) begin
            step("rand", ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 7) == 0), $urandom, $urandom);
        end

        step("preRst", 1'b1, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0);
        iRstN = 1'b0;
        #1;
        chk("midrst_async", oData, 64'd0);
        #1;
        iRstN = 1'b1;
        model = '0;
        step("postRst_hold", 1'b0, 1'b0, 32'd5, 32'd5);
        step("postRst_load", 1'b1, 1'b0, 32'd5, 32'd6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
